// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial sequence generator/detector pair:
// FSM state encoding, default pattern geometry and PRBS7 constants.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int           DEFAULT_PAT_W  = 5;
  localparam logic [4:0]   DETECT_PATTERN = 5'b10101;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback from bits 6 and 5.
  localparam logic [6:0]   PRBS7_SEED     = 7'h7F;
  localparam logic [6:0]   PRBS7_TAPS     = 7'b110_0000;

endpackage

// File: rtl/sequence_tx_prbs7_gen.sv
// PRBS7 (x^7+x^6+1) generator; advances one step per enabled cycle.
// out_bit is the current MSB of the LFSR.
module prbs7_gen
  import seqdet_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic out_bit
);

  logic [6:0] lfsr_q;

  // LFSR register: seeded on reset, shifts left with XOR feedback when enabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr_q <= PRBS7_SEED;
    end else if (enable) begin
      lfsr_q <= {lfsr_q[5:0], ^(lfsr_q & PRBS7_TAPS)};
    end
  end

  assign out_bit = lfsr_q[6];

endmodule

// File: rtl/sequence_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first,
// repeat_cnt times, with gap_cycles idle cycles between frames.
// Optional macro SEQUENCE_TX_PRBS_FILL_EN fills gap cycles with PRBS7 data.
module sequence_tx
  import seqdet_pkg::*;
#(
  parameter int PAT_W = DEFAULT_PAT_W,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             output_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BC_W     = $clog2(PAT_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PAT_W - 1);

  state_t            state_q,   state_d;
  logic [PAT_W-1:0]  shreg_q,   shreg_d;
  logic [PAT_W-1:0]  pat_q,     pat_d;
  logic [CNT_W-1:0]  frames_q,  frames_d;
  logic [GAP_W-1:0]  gap_len_q, gap_len_d;
  logic [GAP_W-1:0]  gap_q,     gap_d;
  logic [BC_W-1:0]   bit_q,     bit_d;

  logic out_bit_d, valid_d, busy_d, done_d;
  logic fill_bit;

`ifdef SEQUENCE_TX_PRBS_FILL_EN
  logic prbs_en;
  logic prbs_bit;

  // Advances exactly once for every gap cycle presented on the output.
  assign prbs_en  = (state_d == GAP);
  assign fill_bit = prbs_bit;

  prbs7_gen u_prbs (
    .clock   (clock),
    .reset   (reset),
    .enable  (prbs_en),
    .out_bit (prbs_bit)
  );
`else
  assign fill_bit = 1'b0;
`endif

  // Next-state, counter and next-output logic. Outputs are computed from the
  // next state so that they can be registered with the state itself.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    frames_d  = frames_q;
    gap_len_d = gap_len_q;
    gap_d     = gap_q;
    bit_d     = bit_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern_in;
          frames_d  = repeat_cnt;
          gap_len_d = gap_cycles;
          bit_d     = '0;
          gap_d     = '0;
          if (repeat_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            shreg_d = pattern_in;
          end
        end
      end

      SEND: begin
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
          if (frames_q == CNT_W'(1)) begin
            frames_d = '0;
            state_d  = DONE;
          end else begin
            frames_d = frames_q - CNT_W'(1);
            if (gap_len_q == '0) begin
              shreg_d = pat_q;
            end else begin
              gap_d   = gap_len_q;
              state_d = GAP;
            end
          end
        end else begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + BC_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          gap_d   = '0;
          shreg_d = pat_q;
          bit_d   = '0;
          state_d = SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d   = (state_d == SEND);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    out_bit_d = 1'b0;
    if (state_d == SEND) begin
      out_bit_d = shreg_d[PAT_W-1];
    end else if (state_d == GAP) begin
      out_bit_d = fill_bit;
    end
  end

  // State, counters and registered outputs; reset aborts any job at once.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      pat_q      <= '0;
      frames_q   <= '0;
      gap_len_q  <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      output_bit <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      pat_q      <= pat_d;
      frames_q   <= frames_d;
      gap_len_q  <= gap_len_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      output_bit <= out_bit_d;
      bit_valid  <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_sequence_tx.sv
// Scoreboard bench for sequence_tx: each accepted job expands into a
// per-cycle trace of {output_bit, bit_valid, busy, done}; a monitor pops and
// compares one entry per cycle (empty queue means the idle vector).
module tb_sequence_tx;

  localparam int PAT_W = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic             output_bit, bit_valid, busy, done;

  sequence_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pattern_in (pattern_in),
    .repeat_cnt (repeat_cnt),
    .gap_cycles (gap_cycles),
    .output_bit (output_bit),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  logic [3:0] exp_q[$];
  logic [3:0] cur_exp = '0;
  bit         chk_on  = 1'b0;
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         cyc     = 0;

  // Expand a job into its expected output trace, one entry per cycle.
  function automatic void push_job(logic [PAT_W-1:0] p, logic [CNT_W-1:0] r,
                                   logic [GAP_W-1:0] g);
    int frames = int'(r);
    int gaps   = int'(g);
    for (int f = 0; f < frames; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (f < frames - 1)
        for (int k = 0; k < gaps; k++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
  endfunction

  // Monitor: compare the DUT outputs against the scoreboard every cycle.
  always @(negedge clock) begin
    if (chk_on) begin
      logic [3:0] act;
      logic [3:0] e;
      act = {output_bit, bit_valid, busy, done};
      e   = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
      cur_exp = e;
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL trace cyc=%0d out/valid/busy/done got=%b expected=%b",
                 cyc, act, e);
      end
    end
  end

  // One clock of stimulus; the model accepts start only when the expected
  // DUT state for the current cycle is idle (not busy, including DONE).
  task automatic step(input logic rst, input logic st, input logic [PAT_W-1:0] p,
                      input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g);
    @(negedge clock);
    reset      = rst;
    start      = st;
    pattern_in = p;
    repeat_cnt = r;
    gap_cycles = g;
    @(posedge clock);
    cyc++;
    if (!rst) begin
      exp_q.delete();
    end else if (st && !cur_exp[1] && exp_q.size() == 0) begin
      push_job(p, r, g);
    end
    chk_on = 1'b1;
  endtask

  task automatic hold(input int n, input logic rst, input logic st,
                      input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                      input logic [GAP_W-1:0] g);
    for (int i = 0; i < n; i++) step(rst, st, p, r, g);
  endtask

  initial begin
    // Reset, then the directed scenarios.
    hold(3, 1'b0, 1'b0, '0, '0, '0);
    hold(2, 1'b1, 1'b0, '0, '0, '0);

    // Single frame.
    hold(1, 1'b1, 1'b1, 5'b10101, 8'd1, 4'd0);
    hold(8, 1'b1, 1'b0, 5'b10101, 8'd1, 4'd0);

    // Gapped repeats.
    hold(1, 1'b1, 1'b1, 5'b10101, 8'd3, 4'd2);
    hold(22, 1'b1, 1'b0, 5'b10101, 8'd3, 4'd2);

    // Back-to-back frames with a non-symmetric pattern.
    hold(1, 1'b1, 1'b1, 5'b11001, 8'd2, 4'd0);
    hold(13, 1'b1, 1'b0, 5'b00000, 8'd7, 4'd9);

    // Zero frames.
    hold(1, 1'b1, 1'b1, 5'b11111, 8'd0, 4'd3);
    hold(4, 1'b1, 1'b0, 5'b11111, 8'd0, 4'd3);

    // Reset on the third bit, then a fresh job.
    hold(1, 1'b1, 1'b1, 5'b10110, 8'd2, 4'd1);
    hold(2, 1'b1, 1'b0, 5'b10110, 8'd2, 4'd1);
    hold(1, 1'b0, 1'b0, 5'b10110, 8'd2, 4'd1);
    hold(1, 1'b1, 1'b1, 5'b10011, 8'd1, 4'd0);
    hold(8, 1'b1, 1'b0, 5'b10011, 8'd1, 4'd0);

    // Start pulses while busy, and start held high through DONE.
    hold(1, 1'b1, 1'b1, 5'b10101, 8'd2, 4'd3);
    hold(3, 1'b1, 1'b0, 5'b10101, 8'd2, 4'd3);
    hold(1, 1'b1, 1'b1, 5'b01010, 8'd5, 4'd0);
    hold(9, 1'b1, 1'b0, 5'b01010, 8'd5, 4'd0);
    hold(30, 1'b1, 1'b1, 5'b11010, 8'd1, 4'd1);
    hold(10, 1'b1, 1'b0, 5'b11010, 8'd1, 4'd1);

    // Maximum repeat count and maximum gap.
    hold(1, 1'b1, 1'b1, 5'b10001, 8'd255, 4'd0);
    hold(1290, 1'b1, 1'b0, 5'b01110, 8'd3, 4'd5);
    hold(1, 1'b1, 1'b1, 5'b11100, 8'd3, 4'd15);
    hold(60, 1'b1, 1'b0, 5'b00111, 8'd1, 4'd1);

    // Randomized traffic with mid-job input changes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic             rst;
      logic             st;
      logic [PAT_W-1:0] p;
      logic [CNT_W-1:0] r;
      logic [GAP_W-1:0] g;
      rst = ($urandom_range(0, 249) != 0);
      st  = ($urandom_range(0, 3) == 0);
      p   = PAT_W'($urandom);
      r   = CNT_W'($urandom_range(0, 5));
      g   = GAP_W'($urandom_range(0, 4));
      step(rst, st, p, r, g);
    end

    // Drain and confirm every expected cycle was consumed.
    hold(1400, 1'b1, 1'b0, '0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending_entries got=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequence_tx.md
Name: sequence_tx

Overview:
Serial pattern transmitter: the generator side of the 5-bit serial sequence detector.
- Emits a programmable PAT_W-bit pattern MSB-first, one bit per clock.
- Frame is repeated repeat_cnt times, with gap_cycles idle cycles between frames.
- Drives the detector's input_bit stream in self-test and demo builds; also usable as a generic serial stimulus source.

Parameters:
PAT_W, 5, pattern length in bits (>=2); default matches detector pattern 10101.
CNT_W, 8, width of repeat counter.
GAP_W, 4, width of inter-frame gap counter.

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
start  input  1  request; accepted only in IDLE.
pattern_in  input  PAT_W  pattern, captured at accept; bit PAT_W-1 sent first.
repeat_cnt  input  CNT_W  frames to send, captured at accept.
gap_cycles  input  GAP_W  idle cycles between frames, captured at accept.
output_bit  output  1  serial data (registered).
bit_valid  output  1  high while output_bit carries a pattern bit.
busy  output  1  high from cycle after accept until DONE cycle inclusive.
done  output  1  one-cycle pulse at end of job.

Behaviour:
- Reset (reset==0 at posedge):
  - Forces state IDLE.
  - output_bit=0, bit_valid=0, busy=0, done=0; shift reg, bit/frame/gap counters cleared.
  - Reset mid-frame aborts immediately; no partial frame completion.
- All outputs registered; no combinational path from inputs to outputs.
- States (2-bit encoding): IDLE=00, SEND=01, GAP=10, DONE=11.
- IDLE:
  - start=1 captures pattern_in, repeat_cnt, gap_cycles.
  - repeat_cnt==0: go to DONE.
  - Otherwise go to SEND, loading the shift reg.
- Latency: first pattern bit is on output_bit, with bit_valid=1, in the cycle after start is accepted.
- SEND:
  - Each cycle drive shift reg MSB, shift left, bit_valid=1; exactly PAT_W cycles per frame.
  - On the last bit, decrement the frame counter:
    - 0 left -> DONE;
    - else if gap==0 -> reload pattern, stay in SEND (back-to-back, no bubble);
    - else -> GAP.
- GAP: bit_valid=0, output_bit=0; exactly gap_cycles cycles, then reload pattern, enter SEND.
- DONE: done=1, busy=1, bit_valid=0 for one cycle; then IDLE (busy=0).
- start is ignored while busy, including the DONE cycle. A start held high re-triggers on the first IDLE cycle.
- Mid-job changes on pattern_in, repeat_cnt or gap_cycles have no effect.
- Max job: repeat_cnt=2^CNT_W-1 frames; counters never wrap during a job.

Optional Feature:
SEQUENCE_TX_PRBS_FILL_EN:
- Defined: during GAP, output_bit carries PRBS7 (x^7+x^6+1, seed 7'h7F at reset), with bit_valid=0. The LFSR advances only in GAP cycles. This stresses detector false-match rejection.
- Undefined: GAP output_bit is constant 0; no LFSR logic is instantiated.

Decomposition:
- Package seqdet_pkg:
  - state encoding constants (IDLE/SEND/GAP/DONE);
  - DEFAULT_PAT_W=5;
  - DETECT_PATTERN=5'b10101;
  - PRBS7 seed and tap constants.
- One sub-module, prbs7_gen (enable, 1-bit out), instantiated only under SEQUENCE_TX_PRBS_FILL_EN.
- Counters and FSM stay in sequence_tx.

Test Plan:
- Single frame: pattern_in=10101, repeat_cnt=1, gap_cycles=0, start pulse at cycle 0 -> output_bit 1,0,1,0,1 in cycles 1-5, bit_valid high cycles 1-5, done pulse cycle 6, busy low cycle 7. With the detector attached, output_indicator high exactly once.
- Gapped repeats: repeat_cnt=3, gap_cycles=2 -> sequence 10101 00 10101 00 10101 over cycles 1-19, bit_valid low in cycles 6-7 and 13-14, done at cycle 20.
- Back-to-back: repeat_cnt=2, gap_cycles=0 -> 1010110101 in cycles 1-10 with no bubble; detector reports 2 matches.
- Zero frames: repeat_cnt=0 -> done at cycle 1, bit_valid never asserted.
- Reset mid-frame: drive reset=0 on the 3rd bit -> next cycle all outputs 0, state IDLE; a fresh start then sends the full pattern from MSB.
- Start while busy: start asserted during SEND and during DONE -> ignored, bit stream unchanged. Start held high through DONE -> new job accepted on the first IDLE cycle.
